// File: rtl/array_fill_pkg.sv
// rtl/array_fill_pkg.sv - shared types and constants for the array fill writer
// Contents: FSM state enum, default WIDTH/DEPTH, request mode encodings.
package array_fill_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 4;

    localparam logic MODE_SINGLE = 1'b0;
    localparam logic MODE_BURST  = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/array_fill_store.sv
// rtl/array_fill_store.sv - register array with one write port and optional parity
// Ports: clk, rst_n (sync active-low), we/waddr/wdata (write port),
//        out_array (flattened entries, entry i at [i*WIDTH +: WIDTH]),
//        out_parity (only with ARRAY_FILL_WRITER_PARITY_EN: per-entry XOR).
module array_fill_store
    import array_fill_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int IW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   we,
    input  logic [IW-1:0]          waddr,
    input  logic [WIDTH-1:0]       wdata,
    output logic [DEPTH*WIDTH-1:0] out_array
`ifdef ARRAY_FILL_WRITER_PARITY_EN
    ,
    output logic [DEPTH-1:0]       out_parity
`endif
);

    logic [DEPTH-1:0][WIDTH-1:0] mem;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Packed array flattens with entry 0 in the least significant slice.
    assign out_array = mem;

`ifdef ARRAY_FILL_WRITER_PARITY_EN
    logic [DEPTH-1:0] par;

    // Parity is computed from the write data so it lands on the same edge as the entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            par <= '0;
        end else if (we) begin
            par[waddr] <= ^wdata;
        end
    end

    assign out_parity = par;
`endif

endmodule

// File: rtl/array_fill_writer.sv
// rtl/array_fill_writer.sv - single-write / burst-fill controller over a small register array
// Ports: clk, rst_n (sync active-low); in_valid/in_ready request handshake;
//        in_mode (0 single, 1 burst), in_data (data or base), in_index (entry or start);
//        out_array (entries), out_busy (FILL), out_done (one-cycle completion pulse);
//        out_parity only when ARRAY_FILL_WRITER_PARITY_EN is defined.
module array_fill_writer
    import array_fill_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int IW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_mode,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [IW-1:0]          in_index,
    output logic [DEPTH*WIDTH-1:0] out_array,
    output logic                   out_busy,
    output logic                   out_done
`ifdef ARRAY_FILL_WRITER_PARITY_EN
    ,
    output logic [DEPTH-1:0]       out_parity
`endif
);

    state_t           state, state_next;
    logic [WIDTH-1:0] base;
    logic [IW-1:0]    start;
    logic [IW-1:0]    k;

    logic             accept;
    logic             we;
    logic [IW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;

    assign accept = in_valid && (state == IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        we         = 1'b0;
        waddr      = '0;
        wdata      = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (in_mode == MODE_BURST) begin
                        state_next = FILL;
                    end else begin
                        state_next = DONE;
                        we         = 1'b1;
                        waddr      = in_index;
                        wdata      = in_data;
                    end
                end
            end
            FILL: begin
                // Index and data both wrap naturally in their own widths.
                we    = 1'b1;
                waddr = start + k;
                wdata = base + WIDTH'(k);
                if (k == IW'(DEPTH - 1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            base  <= '0;
            start <= '0;
            k     <= '0;
        end else if (accept && (in_mode == MODE_BURST)) begin
            base  <= in_data;
            start <= in_index;
            k     <= '0;
        end else if (state == FILL) begin
            k <= k + 1'b1;
        end
    end

    assign in_ready = (state == IDLE);
    assign out_busy = (state == FILL);
    assign out_done = (state == DONE);

    array_fill_store #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_store (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .out_array (out_array)
`ifdef ARRAY_FILL_WRITER_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

endmodule
